// File: rtl/input_debouncer.sv
// Multi-channel two-flop synchronizer and debouncer. Each channel has a debounced
// level and single-cycle rise/fall pulses. Every output is driven straight from a flop.
module input_debouncer #(
  parameter int WIDTH        = 4,
  parameter int STABLE_COUNT = 1250000,
  parameter int CNT_W        = 21
) (
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_raw_in,
  output logic [WIDTH-1:0]   o_level,
  output logic [WIDTH-1:0]   o_rise,
  output logic [WIDTH-1:0]   o_fall,
  output logic [2*WIDTH-1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CHK_HI    = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CHK_LO    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  state_t                      r_state     [WIDTH];
  state_t                      w_state_nxt [WIDTH];
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]            r_level;
  logic [WIDTH-1:0]            r_rise;
  logic [WIDTH-1:0]            r_fall;
  logic [WIDTH-1:0]            w_level_nxt;
  logic [WIDTH-1:0]            w_rise_nxt;
  logic [WIDTH-1:0]            w_fall_nxt;

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE_LO;
      end
    end else begin
      r_sync1 <= i_raw_in;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // A single opposite sample during a check drops back to the stable state;
  // entering a check always restarts the count from zero.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_STABLE_LO: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = ST_CHK_HI;
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_CHK_HI: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = ST_STABLE_LO;
          end else if (r_cnt[i] == LP_LAST) begin
            w_state_nxt[i] = ST_STABLE_HI;
            w_level_nxt[i] = 1'b1;
            w_rise_nxt[i]  = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        ST_STABLE_HI: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = ST_CHK_LO;
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_CHK_LO: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = ST_STABLE_HI;
          end else if (r_cnt[i] == LP_LAST) begin
            w_state_nxt[i] = ST_STABLE_LO;
            w_level_nxt[i] = 1'b0;
            w_fall_nxt[i]  = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = ST_STABLE_LO;
        end
      endcase
    end
  end

  always_comb begin
    o_dbg_state = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_dbg_state[2*i +: 2] = r_state[i];
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
